// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Supplies the CPU_WIDTH default (64) when the build does not define it.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

package ifu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DRAIN
   } ifu_state_e;

   localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifu_inst_buf.sv
// Single-entry {pc, instruction} capture register feeding decode.
// Async reset returns it to the reset PC holding a NOP.
module ifu_inst_buf
   import ifu_pkg::*;
#(
   parameter int unsigned          CPU_WIDTH = 64,
   parameter logic [31:0]          NOP_INST  = 32'h00000013,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(IFU_RESET_PC)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic [CPU_WIDTH-1:0] i_pc,
   input  logic [31:0]          i_inst,
   output logic [CPU_WIDTH-1:0] o_pc,
   output logic [31:0]          o_inst
);

   logic [CPU_WIDTH-1:0] r_pc;
   logic [31:0]          r_inst;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc   <= RESET_PC;
         r_inst <= NOP_INST;
      end else if (i_load) begin
         r_pc   <= i_pc;
         r_inst <= i_inst;
      end
   end

   assign o_pc   = r_pc;
   assign o_inst = r_inst;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, single-entry output buffer.
// Optional IFU_MISALIGN_CHK_EN turns a misaligned PC into a flagged NOP without fetching.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int unsigned CPU_WIDTH = `CPU_WIDTH,
   parameter logic [31:0] NOP_INST  = 32'h00000013
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pre_valid,
   output logic                 o_pre_ready,
   input  logic [CPU_WIDTH-1:0] i_pc,
   input  logic                 i_flush,
   output logic                 o_imem_req,
   output logic [CPU_WIDTH-1:0] o_imem_addr,
   input  logic                 i_imem_gnt,
   input  logic                 i_imem_rvalid,
   input  logic [31:0]          i_imem_rdata,
   output logic                 o_post_valid,
   input  logic                 i_post_ready,
`ifdef IFU_MISALIGN_CHK_EN
   output logic                 o_misalign,
`endif
   output logic [31:0]          o_inst,
   output logic [CPU_WIDTH-1:0] o_pc
);

   ifu_state_e           r_state;
   logic [CPU_WIDTH-1:0] r_pc;
   logic                 w_pre_fire;
   logic                 w_accept;
   logic                 w_mis;
   logic                 w_rsp_load;
   logic                 w_buf_load;
   logic [CPU_WIDTH-1:0] w_buf_pc;
   logic [31:0]          w_buf_inst;

   assign o_pre_ready = (r_state == IDLE) | ((r_state == HOLD) & i_post_ready);
   assign w_pre_fire  = i_pre_valid & o_pre_ready;
   assign w_accept    = w_pre_fire & ~i_flush;

`ifdef IFU_MISALIGN_CHK_EN
   assign w_mis = (i_pc[1:0] != 2'b00);
`else
   assign w_mis = 1'b0;
`endif

   // Buffer loads either a memory response or a synthesized NOP for a misaligned PC.
   assign w_rsp_load = (r_state == WAIT) & i_imem_rvalid & ~i_flush;
   assign w_buf_load = w_rsp_load | (w_accept & w_mis);
   assign w_buf_pc   = w_rsp_load ? r_pc : i_pc;
   assign w_buf_inst = w_rsp_load ? i_imem_rdata : NOP_INST;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_pc    <= CPU_WIDTH'(IFU_RESET_PC);
      end else begin
         if (w_accept) r_pc <= i_pc;
         case (r_state)
            IDLE, HOLD: begin
               if (w_accept)
                  r_state <= w_mis ? HOLD : REQ;
               else if ((r_state == HOLD) && (i_post_ready || i_flush))
                  r_state <= IDLE;
            end
            REQ: begin
               if (i_flush)         r_state <= i_imem_gnt ? DRAIN : IDLE;
               else if (i_imem_gnt) r_state <= WAIT;
            end
            WAIT: begin
               if (i_imem_rvalid) r_state <= i_flush ? IDLE : HOLD;
               else if (i_flush)  r_state <= DRAIN;
            end
            DRAIN: begin
               if (i_imem_rvalid) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_imem_req   = (r_state == REQ);
   assign o_imem_addr  = r_pc;
   assign o_post_valid = (r_state == HOLD) & ~i_flush;

`ifdef IFU_MISALIGN_CHK_EN
   logic r_misalign;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)           r_misalign <= 1'b0;
      else if (w_buf_load) r_misalign <= ~w_rsp_load;
   end

   assign o_misalign = r_misalign & (r_state == HOLD);
`endif

   ifu_inst_buf #(
      .CPU_WIDTH (CPU_WIDTH),
      .NOP_INST  (NOP_INST),
      .RESET_PC  (CPU_WIDTH'(IFU_RESET_PC))
   ) u_inst_buf (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (w_buf_load),
      .i_pc   (w_buf_pc),
      .i_inst (w_buf_inst),
      .o_pc   (o_pc),
      .o_inst (o_inst)
   );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed and randomized bench for ifu_fetch; random phase uses a transaction-level
// scoreboard (queue of accepted PCs, memory content as a function of address).
module tb_ifu_fetch;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_pre_valid;
   logic        o_pre_ready;
   logic [63:0] i_pc;
   logic        i_flush;
   logic        o_imem_req;
   logic [63:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_post_valid;
   logic        i_post_ready;
   logic [31:0] o_inst;
   logic [63:0] o_pc;
`ifdef IFU_MISALIGN_CHK_EN
   logic        o_misalign;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   bit          pend;
   bit          drain;
   logic [31:0] pend_data;
   int          n_xfer;

   ifu_fetch dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_pre_valid   (i_pre_valid),
      .o_pre_ready   (o_pre_ready),
      .i_pc          (i_pc),
      .i_flush       (i_flush),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_post_valid  (o_post_valid),
      .i_post_ready  (i_post_ready),
`ifdef IFU_MISALIGN_CHK_EN
      .o_misalign    (o_misalign),
`endif
      .o_inst        (o_inst),
      .o_pc          (o_pc)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] mem_of(input logic [63:0] a);
      return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Full fetch: accept, grant next cycle, response the cycle after; ends in HOLD.
   task automatic fetch(input logic [63:0] pc, input logic [31:0] data);
      i_pre_valid = 1'b1;
      i_pc        = pc;
      #1;
      chk1("fetch_pre_ready", o_pre_ready, 1'b1);
      step();
      i_pre_valid  = 1'b0;
      i_post_ready = 1'b0;
      #1;
      chk1("fetch_req", o_imem_req, 1'b1);
      chk("fetch_addr", o_imem_addr, pc);
      i_imem_gnt = 1'b1;
      step();
      i_imem_gnt    = 1'b0;
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = data;
      #1;
      chk1("fetch_wait_req", o_imem_req, 1'b0);
      chk1("fetch_wait_valid", o_post_valid, 1'b0);
      step();
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0;
      #1;
      chk1("fetch_post_valid", o_post_valid, 1'b1);
      chk("fetch_inst", 64'(o_inst), 64'(data));
      chk("fetch_pc", o_pc, pc);
   endtask

   task automatic transfer();
      i_post_ready = 1'b1;
      step();
      i_post_ready = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_pre_valid = 1'b0; i_pc = '0; i_flush = 1'b0;
      i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_post_ready = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk1("rst_req", o_imem_req, 1'b0);
      chk1("rst_post_valid", o_post_valid, 1'b0);
      chk("rst_inst", 64'(o_inst), 64'(NOP));
      chk("rst_pc", o_pc, RPC);
      i_rst = 1'b0;
      #1;
      chk1("rst_pre_ready", o_pre_ready, 1'b1);

      // Basic fetch with N+3 latency
      fetch(64'h8000_0000, 32'h0010_0093);

      // Decode stalls for 4 cycles in HOLD
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stall_inst", 64'(o_inst), 64'h0010_0093);
         chk("stall_pc", o_pc, 64'h8000_0000);
         chk1("stall_pre_ready", o_pre_ready, 1'b0);
         chk1("stall_valid", o_post_valid, 1'b1);
      end
      i_post_ready = 1'b1;
      #1;
      chk1("ready_pre_ready", o_pre_ready, 1'b1);
      fetch(64'h8000_0004, 32'h0020_0113);
      transfer();

      // Flush while waiting for the response; late response must be dropped
      i_pre_valid = 1'b1; i_pc = 64'h8000_0008;
      step();
      i_pre_valid = 1'b0; i_imem_gnt = 1'b1;
      step();
      i_imem_gnt = 1'b0; i_flush = 1'b1;
      #1;
      chk1("wflush_valid", o_post_valid, 1'b0);
      step();
      i_flush = 1'b0;
      #1;
      chk1("drain_pre_ready", o_pre_ready, 1'b0);
      chk1("drain_valid", o_post_valid, 1'b0);
      step();
      i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk1("drain_rsp_valid", o_post_valid, 1'b0);
      step();
      i_imem_rvalid = 1'b0;
      #1;
      chk1("drain_done_ready", o_pre_ready, 1'b1);
      chk1("drain_done_valid", o_post_valid, 1'b0);
      chk("drain_inst_kept", 64'(o_inst), 64'h0020_0113);
      fetch(64'h8000_0100, 32'h0030_0193);
      transfer();

      // Grant withheld; flush on the third request cycle withdraws it
      i_pre_valid = 1'b1; i_pc = 64'h8000_0200;
      step();
      i_pre_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk1("nogrant_req", o_imem_req, 1'b1);
         chk("nogrant_addr", o_imem_addr, 64'h8000_0200);
         if (k == 2) i_flush = 1'b1;
         step();
      end
      i_flush = 1'b0;
      #1;
      chk1("withdraw_req", o_imem_req, 1'b0);
      chk1("withdraw_idle", o_pre_ready, 1'b1);

      // Flush on the PC handshake discards the PC
      i_pre_valid = 1'b1; i_flush = 1'b1; i_pc = 64'h8000_0400;
      #1;
      chk1("hsflush_pre_ready", o_pre_ready, 1'b1);
      step();
      i_pre_valid = 1'b0; i_flush = 1'b0;
      #1;
      chk1("hsflush_no_req", o_imem_req, 1'b0);

      // Flush together with grant drains the outstanding response
      i_pre_valid = 1'b1; i_pc = 64'h8000_0500;
      step();
      i_pre_valid = 1'b0; i_imem_gnt = 1'b1; i_flush = 1'b1;
      step();
      i_imem_gnt = 1'b0; i_flush = 1'b0;
      #1;
      chk1("rflush_drain", o_pre_ready, 1'b0);
      i_imem_rvalid = 1'b1; i_imem_rdata = 32'h1111_2222;
      step();
      i_imem_rvalid = 1'b0;
      #1;
      chk1("rflush_idle", o_pre_ready, 1'b1);
      chk1("rflush_valid", o_post_valid, 1'b0);

      // Flush in HOLD kills the pending instruction
      fetch(64'h8000_0600, 32'h0040_0213);
      i_flush = 1'b1;
      #1;
      chk1("hflush_valid", o_post_valid, 1'b0);
      step();
      i_flush = 1'b0;
      #1;
      chk1("hflush_idle_valid", o_post_valid, 1'b0);
      chk1("hflush_idle_ready", o_pre_ready, 1'b1);

      // Asynchronous reset in WAIT; stale response afterwards is ignored
      i_pre_valid = 1'b1; i_pc = 64'h8000_0700;
      step();
      i_pre_valid = 1'b0; i_imem_gnt = 1'b1;
      step();
      i_imem_gnt = 1'b0; i_rst = 1'b1;
      #1;
      chk1("arst_valid", o_post_valid, 1'b0);
      chk("arst_pc", o_pc, RPC);
      chk("arst_inst", 64'(o_inst), 64'(NOP));
      chk1("arst_req", o_imem_req, 1'b0);
      step();
      i_rst = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hCAFE_F00D;
      #1;
      chk1("arst_pre_ready", o_pre_ready, 1'b1);
      step();
      i_imem_rvalid = 1'b0;
      #1;
      chk1("stale_valid", o_post_valid, 1'b0);
      chk("stale_inst", 64'(o_inst), 64'(NOP));
      chk1("stale_req", o_imem_req, 1'b0);

`ifdef IFU_MISALIGN_CHK_EN
      // Misaligned PC bypasses memory and presents a flagged NOP
      i_pre_valid = 1'b1; i_pc = 64'h8000_0002;
      step();
      i_pre_valid = 1'b0;
      #1;
      chk1("mis_req", o_imem_req, 1'b0);
      chk1("mis_valid", o_post_valid, 1'b1);
      chk1("mis_flag", o_misalign, 1'b1);
      chk("mis_inst", 64'(o_inst), 64'(NOP));
      chk("mis_pc", o_pc, 64'h8000_0002);
      transfer();
      fetch(64'h8000_0010, 32'h0050_0293);
      chk1("aligned_flag", o_misalign, 1'b0);
      transfer();
`else
      // Low PC bits are passed through untouched
      fetch(64'h8000_0002, 32'h0050_0293);
      transfer();
`endif

      // Randomized traffic against a transaction-level scoreboard
      pend = 1'b0; n_xfer = 0;
      exp_q.delete();
      for (int c = 0; c < 3000; c++) begin
         drain         = (c >= 2700);
         i_post_ready  = drain || ($urandom_range(3) != 0);
         i_imem_gnt    = drain || ($urandom_range(1) == 1);
         i_imem_rvalid = pend && (drain || ($urandom_range(2) != 0));
         i_imem_rdata  = i_imem_rvalid ? pend_data : 32'($urandom);
         i_pre_valid   = !drain && ($urandom_range(1) == 1);
         i_pc          = {$urandom, $urandom} & ~64'h3;
         #1;
         if (o_post_valid && i_post_ready) begin
            chk1("rnd_xfer_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               chk("rnd_pc", o_pc, exp_q[0]);
               chk("rnd_inst", 64'(o_inst), 64'(mem_of(exp_q[0])));
               void'(exp_q.pop_front());
               n_xfer++;
            end
         end
         if (i_imem_rvalid) pend = 1'b0;
         if (o_imem_req && i_imem_gnt) begin
            chk1("rnd_one_outstanding", pend, 1'b0);
            chk1("rnd_req_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("rnd_addr", o_imem_addr, exp_q[$]);
            pend      = 1'b1;
            pend_data = mem_of(o_imem_addr);
         end
         if (i_pre_valid && o_pre_ready) exp_q.push_back(i_pc);
         step();
      end
      i_pre_valid = 1'b0; i_post_ready = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
      chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
      chk1("rnd_no_pending", pend, 1'b0);
      chk1("rnd_traffic", n_xfer > 50, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter: CPU_WIDTH, `CPU_WIDTH (64), PC/address width.
REQ-002 SHALL have parameter: NOP_INST, 32'h00000013, instruction presented when nothing valid is held.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_pre_valid  in  1  PC offered by branch/PC stage
- o_pre_ready  out  1  PC accepted
- i_pc  in  CPU_WIDTH  PC to fetch
- i_flush  in  1  kill current fetch (taken branch/jump)
- o_imem_req  out  1  memory request
- o_imem_addr  out  CPU_WIDTH  request address
- i_imem_gnt  in  1  request accepted
- i_imem_rvalid  in  1  response valid
- i_imem_rdata  in  32  response instruction
- o_post_valid  out  1  instruction to decode valid
- i_post_ready  in  1  decode accepts
- o_inst  out  32  fetched instruction
- o_pc  out  CPU_WIDTH  PC of o_inst

Function
REQ-004 SHALL implement FSM IDLE, REQ, WAIT, HOLD, DRAIN; at most one memory request outstanding.
REQ-005 o_pre_ready SHALL be (IDLE) | (HOLD & i_post_ready); it SHALL NOT depend on i_flush.
REQ-006 PC handshake (i_pre_valid & o_pre_ready) with i_flush=0 SHALL latch i_pc and enter REQ next cycle; with i_flush=1 the PC SHALL be consumed and discarded (next state IDLE).
REQ-007 REQ: o_imem_req=1, o_imem_addr=latched PC, held stable until i_imem_gnt; gnt -> WAIT.
REQ-008 REQ with i_flush: if i_imem_gnt same cycle -> DRAIN, else request withdrawn -> IDLE.
REQ-009 WAIT: i_imem_rvalid -> capture i_imem_rdata into o_inst, PC into o_pc, -> HOLD; i_flush without rvalid -> DRAIN; i_flush with rvalid -> data discarded, IDLE.
REQ-010 DRAIN: discard the next i_imem_rvalid, then IDLE; o_post_valid=0 throughout.
REQ-011 HOLD: o_post_valid = ~i_flush; o_inst/o_pc stable until transfer; transfer (valid & ready) or i_flush -> IDLE, unless a new PC is accepted in the same cycle (REQ-005, REQ-006) -> REQ.
REQ-012 Latency: PC accepted cycle N, gnt at N+1, rvalid at N+2 -> o_post_valid at N+3; one instruction per 3 cycles minimum.
REQ-013 i_imem_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-014 Assertion of i_rst at any time SHALL force IDLE asynchronously: o_imem_req=0, o_post_valid=0, o_inst=NOP_INST, o_pc=CPU_WIDTH'h80000000, any outstanding response forgotten.
REQ-015 After reset release, o_pre_ready=1 from the first clock edge.

Configuration
REQ-016 Macro IFU_MISALIGN_CHK_EN: when defined, adds output o_misalign (1 bit); a latched PC with pc[1:0]!=0 SHALL skip REQ/WAIT and go directly to HOLD with o_inst=NOP_INST and o_misalign=1 (0 otherwise).
REQ-017 Without IFU_MISALIGN_CHK_EN, port o_misalign SHALL be absent and pc[1:0] SHALL be ignored.

Structure
REQ-018 Shared package ifu_pkg SHALL hold typedef ifu_state_e (the five states) and constant IFU_RESET_PC=64'h80000000.
REQ-019 One sub-module ifu_inst_buf SHALL hold the {o_pc, o_inst} capture register with load and async clear; the FSM SHALL remain in ifu_fetch.

Verification
REQ-020 Bench SHALL cover these scenarios:
- Reset, i_pc=0x80000000 valid, gnt next cycle, rvalid rdata=0x00100093 -> o_post_valid=1 at N+3, o_inst=0x00100093, o_pc=0x80000000.
- i_post_ready=0 for 4 cycles in HOLD -> o_inst/o_pc stable, o_pre_ready=0; ready=1 -> o_pre_ready=1 same cycle, new PC 0x80000004 enters REQ.
- i_flush in WAIT, later rvalid rdata=0xDEADBEEF -> discarded, o_post_valid never 1 for it; next PC 0x80000100 fetched normally.
- i_gnt held 0 for 3 cycles -> o_imem_req=1, o_imem_addr constant; i_flush at cycle 2 -> req drops next cycle, IDLE.
- i_rst asserted mid-WAIT -> o_post_valid=0, o_pc=0x80000000 immediately; stale rvalid after release ignored.
- With IFU_MISALIGN_CHK_EN, i_pc=0x80000002 -> no o_imem_req, o_misalign=1, o_inst=0x00000013.
